// File: rtl/kf6845_pkg.sv
// KF6845 CRTC shared definitions: mode register field offsets,
// the axis register-set layout and a mode-field helper.
package kf6845_pkg;

  localparam int SKEW_LSB      = 0;
  localparam int DEF_SKEW_BITS = 2;
  localparam int POLARITY_BIT  = SKEW_LSB + DEF_SKEW_BITS;

  // Axis register set at the default widths (8/4/2).
  typedef struct packed {
    logic [7:0] total;
    logic [7:0] displayed;
    logic [7:0] sync_position;
    logic [3:0] sync_width;
    logic [1:0] skew;
    logic       polarity;
  } axis_regs_t;

  // Polarity sits directly above the skew field.
  function automatic int polarity_bit(input int skew_bits);
    return SKEW_LSB + skew_bits;
  endfunction

endpackage

// File: rtl/kf6845_sync_width_counter.sv
// Sync pulse width counter: start loads 1 and raises active; each further
// advance counts until the width is reached. Width 0 means 2^W advances.
// Ports: clock, reset_n, advance, start, width[W-1:0] -> active.
module kf6845_sync_width_counter #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         advance,
  input  logic         start,
  input  logic [W-1:0] width,
  output logic         active
);

  logic [W:0] count;
  logic [W:0] limit;

  // One extra bit so the full-range case (2^W) is representable.
  assign limit = (width == '0) ? {1'b1, {W{1'b0}}}
                               : {1'b0, width};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count  <= '0;
      active <= 1'b0;
    end else if (advance) begin
      if (start) begin
        count  <= {{W{1'b0}}, 1'b1};
        active <= 1'b1;
      end else if (active) begin
        if (count == limit) active <= 1'b0;
        else count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/kf6845_axis_timing.sv
// KF6845 axis timing generator (one instance per axis). Define
// KF6845_AXIS_SHADOW_EN to buffer register writes until the line wrap.
// Ports: clock, reset_n, video_clock_enable, count_enable, internal_data_bus,
// write_* strobes -> position, last_count, half_count, display_end,
// display, sync, sync_active.
module kf6845_axis_timing
  import kf6845_pkg::*;
#(
  parameter int COUNTER_WIDTH   = 8,
  parameter int SYNC_WIDTH_BITS = 4,
  parameter int SKEW_BITS       = 2
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     video_clock_enable,
  input  logic                     count_enable,
  input  logic [COUNTER_WIDTH-1:0] internal_data_bus,
  input  logic                     write_total_register,
  input  logic                     write_displayed_register,
  input  logic                     write_sync_position_register,
  input  logic                     write_sync_width_register,
  input  logic                     write_mode_register,
  output logic [COUNTER_WIDTH-1:0] position,
  output logic                     last_count,
  output logic                     half_count,
  output logic                     display_end,
  output logic                     display,
  output logic                     sync,
  output logic                     sync_active
);

  localparam int DEPTH   = 1 << SKEW_BITS;
  localparam int POL_BIT = polarity_bit(SKEW_BITS);

  typedef struct packed {
    logic [COUNTER_WIDTH-1:0]   total;
    logic [COUNTER_WIDTH-1:0]   displayed;
    logic [COUNTER_WIDTH-1:0]   sync_position;
    logic [SYNC_WIDTH_BITS-1:0] sync_width;
    logic [SKEW_BITS-1:0]       skew;
    logic                       polarity;
  } regs_t;

  logic  advance;
  regs_t act;
  regs_t wr_base;
  regs_t wr_next;
  logic  use_new;

  assign advance = video_clock_enable & count_enable;

  always_comb begin
    wr_next = wr_base;
    if (write_total_register)
      wr_next.total = internal_data_bus;
    if (write_displayed_register)
      wr_next.displayed = internal_data_bus;
    if (write_sync_position_register)
      wr_next.sync_position = internal_data_bus;
    if (write_sync_width_register)
      wr_next.sync_width = internal_data_bus[SYNC_WIDTH_BITS-1:0];
    if (write_mode_register) begin
      wr_next.skew     = internal_data_bus[SKEW_LSB +: SKEW_BITS];
      wr_next.polarity = internal_data_bus[POL_BIT];
    end
  end

`ifdef KF6845_AXIS_SHADOW_EN
  regs_t shd;

  assign wr_base = shd;
  // The wrap advance itself runs on the old set; the new line's
  // position-0 flags are computed against the committed set.
  assign use_new = advance & (position == act.total);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shd <= '0;
      act <= '0;
    end else begin
      shd <= wr_next;
      if (use_new) act <= wr_next;
    end
  end
`else
  assign wr_base = act;
  assign use_new = 1'b0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) act <= '0;
    else act <= wr_next;
  end
`endif

  logic [COUNTER_WIDTH-1:0]   eff_total;
  logic [COUNTER_WIDTH-1:0]   eff_displayed;
  logic [COUNTER_WIDTH-1:0]   eff_sync_position;
  logic [SYNC_WIDTH_BITS-1:0] eff_sync_width;
  logic [SKEW_BITS-1:0]       eff_skew;

  assign eff_total         = use_new ? wr_next.total : act.total;
  assign eff_displayed     = use_new ? wr_next.displayed : act.displayed;
  assign eff_sync_position = use_new ? wr_next.sync_position
                                     : act.sync_position;
  assign eff_sync_width    = use_new ? wr_next.sync_width : act.sync_width;
  assign eff_skew          = use_new ? wr_next.skew : act.skew;

  logic [COUNTER_WIDTH-1:0] next_position;
  logic [DEPTH-2:0]         hist;
  logic                     raw_next;
  logic [DEPTH-1:0]         taps;

  // Above total the counter free-runs to its natural overflow.
  assign next_position = (position == act.total) ? '0
                                                 : position + 1'b1;

  // hist[0] is the raw display enable; older bits are its history.
  assign raw_next = (next_position == eff_displayed) ? 1'b0 :
                    (next_position == '0)            ? 1'b1 :
                                                       hist[0];
  assign taps = {hist, raw_next};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      position    <= '0;
      last_count  <= 1'b0;
      half_count  <= 1'b0;
      display_end <= 1'b0;
      display     <= 1'b0;
      hist        <= '0;
    end else if (advance) begin
      position    <= next_position;
      last_count  <= next_position == eff_total;
      half_count  <= next_position == (eff_total >> 1);
      display_end <= next_position == eff_displayed;
      display     <= taps[eff_skew];
      hist        <= taps[DEPTH-2:0];
    end
  end

  kf6845_sync_width_counter #(
    .W(SYNC_WIDTH_BITS)
  ) u_sync_width (
    .clock   (clock),
    .reset_n (reset_n),
    .advance (advance),
    .start   (next_position == eff_sync_position),
    .width   (eff_sync_width),
    .active  (sync_active)
  );

  assign sync = sync_active ^ act.polarity;

endmodule

// File: tb/tb_kf6845_axis_timing.sv
// Directed bench for kf6845_axis_timing (default widths).
// Follows KF6845_AXIS_SHADOW_EN for the mid-line total scenario.
module tb_kf6845_axis_timing;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       video_clock_enable = 1'b0;
  logic       count_enable = 1'b0;
  logic [7:0] internal_data_bus = '0;
  logic       write_total_register = 1'b0;
  logic       write_displayed_register = 1'b0;
  logic       write_sync_position_register = 1'b0;
  logic       write_sync_width_register = 1'b0;
  logic       write_mode_register = 1'b0;
  logic [7:0] position;
  logic       last_count;
  logic       half_count;
  logic       display_end;
  logic       display;
  logic       sync;
  logic       sync_active;

  int vectors = 0;
  int miscompares = 0;

  kf6845_axis_timing dut (
    .clock                        (clock),
    .reset_n                      (reset_n),
    .video_clock_enable           (video_clock_enable),
    .count_enable                 (count_enable),
    .internal_data_bus            (internal_data_bus),
    .write_total_register         (write_total_register),
    .write_displayed_register     (write_displayed_register),
    .write_sync_position_register (write_sync_position_register),
    .write_sync_width_register    (write_sync_width_register),
    .write_mode_register          (write_mode_register),
    .position                     (position),
    .last_count                   (last_count),
    .half_count                   (half_count),
    .display_end                  (display_end),
    .display                      (display),
    .sync                         (sync),
    .sync_active                  (sync_active)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input int sel, input logic [7:0] d);
    internal_data_bus = d;
    case (sel)
      0: write_total_register = 1'b1;
      1: write_displayed_register = 1'b1;
      2: write_sync_position_register = 1'b1;
      3: write_sync_width_register = 1'b1;
      default: write_mode_register = 1'b1;
    endcase
    tick();
    write_total_register = 1'b0;
    write_displayed_register = 1'b0;
    write_sync_position_register = 1'b0;
    write_sync_width_register = 1'b0;
    write_mode_register = 1'b0;
  endtask

  task automatic config_regs(input logic [7:0] t, input logic [7:0] dsp,
                             input logic [7:0] sp, input logic [7:0] sw,
                             input logic [7:0] md);
    video_clock_enable = 1'b0;
    wr(0, t);
    wr(1, dsp);
    wr(2, sp);
    wr(3, sw);
    wr(4, md);
    video_clock_enable = 1'b1;
    count_enable = 1'b1;
  endtask

  // Runs to the end of two lines so new settings are steady.
  task automatic sync_line();
    for (int l = 0; l < 2; l++) begin
      int n = 0;
      do begin
        tick();
        n++;
      end while (!last_count && n < 64);
      vectors++;
      if (last_count !== 1'b1) begin
        miscompares++;
        $display("FAIL sync_line: last_count=%b after %0d clocks, want 1",
                 last_count, n);
      end
    end
  endtask

  task automatic check_line(input int k, input logic pol, input string tag);
    for (int p = 0; p < 10; p++) begin
      logic e_disp;
      logic e_act;
      tick();
      e_disp = ((p - k + 10) % 10) < 6;
      e_act  = p >= 7;
      vectors += 7;
      if (position !== 8'(p)) begin
        miscompares++;
        $display("FAIL %s position: got %0d want %0d", tag, position, p);
      end
      if (last_count !== (p == 9)) begin
        miscompares++;
        $display("FAIL %s last_count p%0d: got %b", tag, p, last_count);
      end
      if (half_count !== (p == 4)) begin
        miscompares++;
        $display("FAIL %s half_count p%0d: got %b", tag, p, half_count);
      end
      if (display_end !== (p == 6)) begin
        miscompares++;
        $display("FAIL %s display_end p%0d: got %b", tag, p, display_end);
      end
      if (display !== e_disp) begin
        miscompares++;
        $display("FAIL %s display p%0d: got %b want %b",
                 tag, p, display, e_disp);
      end
      if (sync_active !== e_act) begin
        miscompares++;
        $display("FAIL %s sync_active p%0d: got %b want %b",
                 tag, p, sync_active, e_act);
      end
      if (sync !== (e_act ^ pol)) begin
        miscompares++;
        $display("FAIL %s sync p%0d: got %b want %b",
                 tag, p, sync, e_act ^ pol);
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    video_clock_enable = 1'b1;
    count_enable = 1'b1;
    tick();
    tick();
    vectors++;
    if ({position, last_count, half_count, display_end,
         display, sync, sync_active} !== 14'd0) begin
      miscompares++;
      $display("FAIL reset outputs: got pos=%0d flags=%b%b%b%b%b%b want 0",
               position, last_count, half_count, display_end,
               display, sync, sync_active);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    config_regs(8'd9, 8'd6, 8'd7, 8'd3, 8'd0);
    sync_line();
    check_line(0, 1'b0, "basic");
  endtask

  task automatic test_skew_polarity();
    video_clock_enable = 1'b0;
    wr(4, 8'd6);
    video_clock_enable = 1'b1;
    sync_line();
    check_line(2, 1'b1, "skew2_pol1");
  endtask

  task automatic test_sync_full_width();
    int n = 0;
    config_regs(8'd19, 8'd6, 8'd7, 8'd0, 8'd0);
    sync_line();
    while (position != 8'd7 && n < 40) begin
      tick();
      n++;
    end
    vectors++;
    if (position !== 8'd7 || sync_active !== 1'b1) begin
      miscompares++;
      $display("FAIL full_width start: pos=%0d active=%b want 7/1",
               position, sync_active);
    end
    n = 1;
    while (n < 40) begin
      tick();
      if (!sync_active) break;
      n++;
    end
    vectors += 2;
    if (n != 16) begin
      miscompares++;
      $display("FAIL full_width length: got %0d want 16", n);
    end
    if (position !== 8'd3) begin
      miscompares++;
      $display("FAIL full_width end: pos=%0d want 3", position);
    end
  endtask

  task automatic test_count_enable();
    int prev;
    config_regs(8'd9, 8'd6, 8'd7, 8'd3, 8'd0);
    sync_line();
    prev = 9;
    for (int i = 0; i < 8; i++) begin
      int ex;
      count_enable = (i % 2 == 0);
      tick();
      ex = count_enable ? (prev + 1) % 10 : prev;
      vectors += 2;
      if (position !== 8'(ex)) begin
        miscompares++;
        $display("FAIL count_enable step%0d: pos=%0d want %0d",
                 i, position, ex);
      end
      if (last_count !== (ex == 9)) begin
        miscompares++;
        $display("FAIL count_enable last step%0d: got %b", i, last_count);
      end
      prev = ex;
    end
    count_enable = 1'b1;
  endtask

  task automatic test_midline_total();
`ifdef KF6845_AXIS_SHADOW_EN
    int exp_pos[12] = '{4, 5, 6, 7, 8, 9, 0, 1, 2, 3, 4, 5};
    bit exp_lst[12] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
`else
    int exp_pos[8] = '{4, 5, 0, 1, 2, 3, 4, 5};
    bit exp_lst[8] = '{0, 1, 0, 0, 0, 0, 0, 1};
`endif
    sync_line();
    for (int i = 0; i < 4; i++) tick();
    vectors++;
    if (position !== 8'd3) begin
      miscompares++;
      $display("FAIL midline setup: pos=%0d want 3", position);
    end
    video_clock_enable = 1'b0;
    wr(0, 8'd5);
    video_clock_enable = 1'b1;
    foreach (exp_pos[i]) begin
      tick();
      vectors += 2;
      if (position !== 8'(exp_pos[i])) begin
        miscompares++;
        $display("FAIL midline pos step%0d: got %0d want %0d",
                 i, position, exp_pos[i]);
      end
      if (last_count !== exp_lst[i]) begin
        miscompares++;
        $display("FAIL midline last step%0d: got %b want %b",
                 i, last_count, exp_lst[i]);
      end
    end
  endtask

  task automatic test_reset_midline();
    config_regs(8'd9, 8'd6, 8'd7, 8'd3, 8'd0);
    sync_line();
    for (int i = 0; i < 8; i++) tick();
    vectors++;
    if (position !== 8'd7 || sync_active !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid setup: pos=%0d active=%b want 7/1",
               position, sync_active);
    end
    #2;
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({position, last_count, half_count, display_end,
         display, sync, sync_active} !== 14'd0) begin
      miscompares++;
      $display("FAIL rst_mid outputs: pos=%0d flags=%b%b%b%b%b%b want 0",
               position, last_count, half_count, display_end,
               display, sync, sync_active);
    end
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    vectors += 3;
    if (position !== 8'd0) begin
      miscompares++;
      $display("FAIL rst_mid restart pos: got %0d want 0", position);
    end
    if (last_count !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid total0 last: got %b want 1", last_count);
    end
    if (half_count !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid total0 half: got %b want 1", half_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_skew_polarity();
    test_sync_full_width();
    test_count_enable();
    test_midline_total();
    test_reset_midline();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
